// File: rtl/ringbuffer_readout_ctrl_pkg.sv
// Shared types for the ring buffer readout controller and its word reader.
// The state encoding is common so both FSMs read the same in a waveform.
package ringbuffer_readout_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_POSTTRIG = 3'd2,
      ST_RD_ADDR  = 3'd3,
      ST_RD_EN    = 3'd4,
      ST_RD_CAP   = 3'd5,
      ST_PRESENT  = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   // Window length PRE+POST, truncated to size+1 bits so a full-buffer window still fits.
   function automatic int unsigned win_len(int unsigned size, int unsigned pre, int unsigned post);
      return (pre + post) & ((32'd1 << (size + 1)) - 32'd1);
   endfunction

endpackage

// File: rtl/ringbuffer_readout_ctrl_if.sv
// Bundle of trigger, ring buffer and downstream stream signals of the readout controller.
interface ringbuffer_readout_ctrl_if #(
   parameter int SIZE  = 10,
   parameter int WIDTH = 14
);
   logic             arm;
   logic             trig;
   logic [SIZE-1:0]  wr_addr;
   logic [WIDTH-1:0] rb_dout;
   logic             wr_en;
   logic             rd_en;
   logic [SIZE-1:0]  rd_addr;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             busy;
   logic             trig_lost;

   modport master (
      input  arm, trig, wr_addr, rb_dout, out_ready,
      output wr_en, rd_en, rd_addr, out_data, out_valid, out_last, busy, trig_lost
   );

   modport slave (
      output arm, trig, wr_addr, rb_dout, out_ready,
      input  wr_en, rd_en, rd_addr, out_data, out_valid, out_last, busy, trig_lost
   );
endinterface

// File: rtl/rb_read_seq.sv
// Single-word read from a 2-cycle-latency buffer: address, enable, capture, then
// present the word on valid/ready until accepted. Runs back-to-back while en_i is high.
module rb_read_seq
   import ringbuffer_readout_ctrl_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] rb_dout_i,
   input  logic             out_ready_i,
   output logic             rd_en_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   output logic             xfer_o
);

   state_t           phase_q, phase_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         phase_q <= ST_RD_ADDR;
         data_q  <= '0;
      end else begin
         phase_q <= phase_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      phase_d     = phase_q;
      data_d      = data_q;
      rd_en_o     = 1'b0;
      out_valid_o = 1'b0;
      xfer_o      = 1'b0;
      if (en_i) begin
         case (phase_q)
            ST_RD_ADDR: phase_d = ST_RD_EN;
            ST_RD_EN: begin
               rd_en_o = 1'b1;
               phase_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
               data_d  = rb_dout_i;
               phase_d = ST_PRESENT;
            end
            ST_PRESENT: begin
               out_valid_o = 1'b1;
               if (out_ready_i) begin
                  xfer_o  = 1'b1;
                  phase_d = ST_RD_ADDR;
               end
            end
            default: phase_d = ST_RD_ADDR;
         endcase
      end else begin
         phase_d = ST_RD_ADDR;
      end
      out_data_o = out_valid_o ? data_q : '0;
   end

endmodule

// File: rtl/ringbuffer_readout_ctrl.sv
// Acquisition sequencer for one ADC ring buffer: arm, pre-fill, trigger, post-trigger
// writes, then stream the frozen PRE+POST window out through rb_read_seq.
module ringbuffer_readout_ctrl
   import ringbuffer_readout_ctrl_pkg::*;
#(
   parameter int SIZE  = 10,
   parameter int WIDTH = 14,
   parameter int PRE   = 64,
   parameter int POST  = 192
) (
   input  logic                     sysclk,
   input  logic                     rst,
   ringbuffer_readout_ctrl_if.master bus
);

   localparam logic [SIZE:0] ONE_C  = (SIZE+1)'(1);
   localparam logic [SIZE:0] PRE_C  = (SIZE+1)'(PRE);
   localparam logic [SIZE:0] POST_C = (SIZE+1)'(POST);
   localparam logic [SIZE:0] LAST_C = (SIZE+1)'(win_len(SIZE, PRE, POST) - 1);

   state_t          state_q, state_d;
   logic [SIZE:0]   fill_q, fill_d;
   logic [SIZE:0]   post_q, post_d;
   logic [SIZE:0]   idx_q, idx_d;
   logic [SIZE-1:0] start_q, start_d;

   logic             wr_en_c, trig_lost_c, rd_active;
   logic             seq_rd_en, seq_valid, seq_xfer;
   logic [WIDTH-1:0] seq_data;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fill_q  <= '0;
         post_q  <= '0;
         idx_q   <= '0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         post_q  <= post_d;
         idx_q   <= idx_d;
         start_q <= start_d;
      end
   end

   // The whole window is read while parked in ST_RD_ADDR; word phases live in rb_read_seq.
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      post_d      = post_q;
      idx_d       = idx_q;
      start_d     = start_q;
      wr_en_c     = 1'b0;
      trig_lost_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.arm) begin
               state_d = ST_ARMED;
               fill_d  = '0;
            end
         end
         ST_ARMED: begin
            wr_en_c = 1'b1;
            if (bus.trig && (fill_q >= PRE_C)) begin
               start_d = bus.wr_addr - SIZE'(PRE);
               post_d  = ONE_C;
               idx_d   = '0;
               state_d = (POST_C == ONE_C) ? ST_RD_ADDR : ST_POSTTRIG;
            end else begin
               trig_lost_c = bus.trig;
               if (fill_q < PRE_C) fill_d = fill_q + ONE_C;
            end
         end
         ST_POSTTRIG: begin
            if (post_q < POST_C) begin
               wr_en_c = 1'b1;
               post_d  = post_q + ONE_C;
            end else begin
               state_d = ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: begin
            if (seq_xfer) begin
               if (idx_q == LAST_C) state_d = ST_DONE;
               else                 idx_d   = idx_q + ONE_C;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_active = (state_q == ST_RD_ADDR);

   rb_read_seq #(.WIDTH(WIDTH)) u_read_seq (
      .sysclk      (sysclk),
      .rst         (rst),
      .en_i        (rd_active),
      .rb_dout_i   (bus.rb_dout),
      .out_ready_i (bus.out_ready),
      .rd_en_o     (seq_rd_en),
      .out_data_o  (seq_data),
      .out_valid_o (seq_valid),
      .xfer_o      (seq_xfer)
   );

   // Outputs are forced low in the reset cycle itself, not only after it.
   assign bus.wr_en     = ~rst & wr_en_c;
   assign bus.rd_en     = ~rst & seq_rd_en;
   assign bus.rd_addr   = (~rst & rd_active) ? (start_q + idx_q[SIZE-1:0]) : '0;
   assign bus.out_data  = rst ? '0 : seq_data;
   assign bus.out_valid = ~rst & seq_valid;
   assign bus.out_last  = ~rst & seq_valid & (idx_q == LAST_C);
   assign bus.busy      = ~rst & (state_q != ST_IDLE);
   assign bus.trig_lost = ~rst & trig_lost_c;

endmodule

// File: tb/tb_ringbuffer_readout_ctrl.sv
// Bench for ringbuffer_readout_ctrl with a 16-word ring buffer model (data = address).
module tb_ringbuffer_readout_ctrl;

   localparam int SIZE  = 4;
   localparam int WIDTH = 4;
   localparam int PRE   = 4;
   localparam int POST  = 8;
   localparam int LEN   = PRE + POST;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ringbuffer_readout_ctrl_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

   ringbuffer_readout_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .PRE(PRE), .POST(POST)) dut (
      .sysclk (clk),
      .rst    (rst),
      .bus    (bus.master)
   );

   // Ring buffer model: write pointer advances per write; 2-cycle read, data = address.
   logic [3:0] wr_ptr   = 4'd0;
   logic [3:0] ain_q    = 4'd0;
   logic [3:0] dout_q   = 4'd0;
   int         n_writes = 0;

   always @(posedge clk) begin
      if (bus.wr_en) begin
         wr_ptr   <= wr_ptr + 4'd1;
         n_writes <= n_writes + 1;
      end
      ain_q <= bus.rd_addr;
      if (bus.rd_en) dout_q <= ain_q;
   end

   assign bus.wr_addr = wr_ptr;
   assign bus.rb_dout = dout_q;

   always @(negedge clk) begin
      assert (!(bus.wr_en && bus.rd_en)) else $error("FAIL wr_rd_excl assertion: wr_en and rd_en both high");
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({bus.wr_en, bus.rd_en, bus.rd_addr, bus.out_data,
                   bus.out_valid, bus.out_last, bus.busy, bus.trig_lost});
   endfunction

   task automatic cycle_end();
      chk("wr_rd_excl", int'(bus.wr_en & bus.rd_en), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic arm_and_trigger(input int pre_wait, input bit noise,
                                  output logic [3:0] trig_a, output int w0);
      bus.arm  = 1'b1;
      bus.trig = 1'b0;
      @(negedge clk);
      chk("idle_wr_en", bus.wr_en, 0);
      chk("idle_busy", bus.busy, 0);
      cycle_end();
      for (int i = 0; i < pre_wait; i++) begin
         bus.arm = noise && (i == 1);
         @(negedge clk);
         chk("armed_wr_en", bus.wr_en, 1);
         chk("armed_busy", bus.busy, 1);
         cycle_end();
      end
      bus.arm  = 1'b0;
      trig_a   = wr_ptr;
      w0       = n_writes;
      bus.trig = 1'b1;
      @(negedge clk);
      chk("trig_wr_en", bus.wr_en, 1);
      chk("trig_no_lost", bus.trig_lost, 0);
      cycle_end();
      bus.trig = 1'b0;
      $display("trigger at wr_addr %0h, window start %0h", trig_a, 4'(trig_a - 4'(PRE)));
   endtask

   // Expected window: LEN consecutive addresses starting PRE before the trigger address.
   task automatic readout(input logic [3:0] trig_a, input int w0, input int stall_word,
                          input int stall_len, input bit rnd_ready, input bit noise, input string tag);
      logic [3:0] exp_start;
      int  k = 0, budget = 600, stalled = 0, since = 0, prev_data = 0, prev_last = 0;
      bit  have_prev = 1'b0, wr_checked = 1'b0;
      exp_start = trig_a - 4'(PRE);
      while (k < LEN && budget > 0) begin
         if (bus.out_valid && k == stall_word && stalled < stall_len) begin
            bus.out_ready = 1'b0;
            stalled++;
         end else begin
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         bus.arm = noise && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         since++;
         if (have_prev) begin
            chk("valid_held", bus.out_valid, 1);
            chk("data_held", bus.out_data, prev_data);
            chk("last_held", bus.out_last, prev_last);
         end
         if (bus.out_valid) begin
            if (!wr_checked) begin
               chk("post_writes", n_writes - w0, POST);
               chk("wr_addr_end", wr_ptr, 4'(trig_a + 4'(POST)));
               wr_checked = 1'b1;
            end
            if (bus.out_ready) begin
               $display("%s word %0d: data %0h last %0d", tag, k, bus.out_data, bus.out_last);
               chk("data", bus.out_data, 4'(exp_start + 4'(k)));
               chk("last", bus.out_last, (k == LEN - 1) ? 1 : 0);
               if (k > 0) chk("spacing_ge4", (since >= 4) ? 1 : 0, 1);
               since     = 0;
               have_prev = 1'b0;
               k++;
            end else begin
               chk("stall_rd_en", bus.rd_en, 0);
               have_prev = 1'b1;
               prev_data = bus.out_data;
               prev_last = bus.out_last;
            end
         end
         cycle_end();
         budget--;
      end
      bus.arm       = 1'b0;
      bus.out_ready = 1'b1;
      if (k < LEN) chk("readout_timeout", k, LEN);
      @(negedge clk);
      chk("done_busy", bus.busy, 1);
      chk("done_valid", bus.out_valid, 0);
      cycle_end();
      @(negedge clk);
      chk("idle_busy_after_done", bus.busy, 0);
      cycle_end();
   endtask

   task automatic run_event(input int pre_wait, input int stall_word, input int stall_len,
                            input bit rnd_ready, input bit noise, input string tag,
                            output logic [3:0] trig_a);
      int w0;
      arm_and_trigger(pre_wait, noise, trig_a, w0);
      readout(trig_a, w0, stall_word, stall_len, rnd_ready, noise, tag);
   endtask

   typedef struct {
      int arm;
      int trig;
      int wr_en;
      int busy;
      int lost;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [3:0] ta;
      int w0, pre, b;

      // Cycle table for the lost-trigger scenario, starting from IDLE.
      tbl[0]  = '{1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 1, 0};
      tbl[2]  = '{0, 1, 1, 1, 1};
      tbl[3]  = '{0, 0, 1, 1, 0};
      tbl[4]  = '{0, 1, 1, 1, 1};
      tbl[5]  = '{0, 0, 1, 1, 0};
      tbl[6]  = '{0, 1, 1, 1, 0};
      tbl[7]  = '{0, 0, 1, 1, 0};
      tbl[8]  = '{0, 0, 1, 1, 0};
      tbl[9]  = '{0, 1, 1, 1, 0};
      tbl[10] = '{1, 1, 1, 1, 0};
      tbl[11] = '{0, 0, 1, 1, 0};
      tbl[12] = '{0, 0, 1, 1, 0};
      tbl[13] = '{0, 0, 1, 1, 0};
      tbl[14] = '{0, 0, 0, 1, 0};

      bus.arm       = 1'b0;
      bus.trig      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outputs", outs(), 0);
      cycle_end();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", outs(), 0);
      cycle_end();

      // Basic event: 10 writes then trigger at address 10.
      run_event(10, -1, 0, 1'b0, 1'b0, "t1", ta);
      chk("t1_trig_addr", ta, 10);

      // Lost triggers while fill < PRE, then a valid one.
      w0 = 0;
      ta = '0;
      for (int i = 0; i < 15; i++) begin
         bus.arm  = tbl[i].arm[0];
         bus.trig = tbl[i].trig[0];
         if (i == 6) begin
            ta = wr_ptr;
            w0 = n_writes;
         end
         @(negedge clk);
         $display("vec %0d: arm %0d trig %0d -> wr_en %0d busy %0d trig_lost %0d",
                  i, bus.arm, bus.trig, bus.wr_en, bus.busy, bus.trig_lost);
         chk($sformatf("tbl%0d_wr_en", i), bus.wr_en, tbl[i].wr_en);
         chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
         chk($sformatf("tbl%0d_trig_lost", i), bus.trig_lost, tbl[i].lost);
         chk($sformatf("tbl%0d_valid", i), bus.out_valid, 0);
         cycle_end();
      end
      bus.arm  = 1'b0;
      bus.trig = 1'b0;
      readout(ta, w0, -1, 0, 1'b0, 1'b0, "t2");

      // Wrap: trigger lands on address 2, window starts at 14.
      pre = int'(4'(4'd2 - wr_ptr));
      if (pre < 4) pre += 16;
      run_event(pre, -1, 0, 1'b0, 1'b0, "t3", ta);
      chk("t3_trig_addr", ta, 2);

      // Seven-cycle stall on word 3.
      run_event(5, 3, 7, 1'b0, 1'b0, "t4", ta);

      // Reset during POSTTRIG.
      arm_and_trigger(6, 1'b0, ta, w0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("posttrig_wr_en", bus.wr_en, 1);
         cycle_end();
      end
      rst      = 1'b1;
      bus.trig = 1'b1;
      @(negedge clk);
      chk("rst_posttrig_outputs", outs(), 0);
      cycle_end();
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_posttrig_outputs", outs(), 0);
      cycle_end();
      bus.trig = 1'b0;
      run_event(4, -1, 0, 1'b0, 1'b0, "t5a", ta);

      // Reset while a word is presented.
      arm_and_trigger(4, 1'b0, ta, w0);
      bus.out_ready = 1'b0;
      b = 0;
      while (!bus.out_valid && b < 50) begin
         @(negedge clk);
         cycle_end();
         b++;
      end
      chk("reach_present", bus.out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_present_outputs", outs(), 0);
      cycle_end();
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("after_rst_present_outputs", outs(), 0);
      cycle_end();
      run_event(9, -1, 0, 1'b0, 1'b0, "t5b", ta);

      // arm pulses during ARMED and readout are ignored.
      run_event(7, -1, 0, 1'b0, 1'b1, "t6", ta);

      // Randomized events against the window model.
      for (int r = 0; r < 8; r++) begin
         pre = int'($urandom_range(4, 22));
         run_event(pre, int'($urandom_range(0, LEN - 1)), int'($urandom_range(0, 5)),
                   1'b1, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r), ta);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ringbuffer_readout_ctrl.md
Name: ringbuffer_readout_ctrl

Overview:
Sequences one ADC ring buffer through an acquisition cycle: arm, continuous write, trigger capture with pre/post-trigger window, freeze, then read out the window. Drives the buffer's wr_en/rd_en/ain and streams the window downstream over a valid/ready interface. Sits between the trigger logic and the ring buffer, which has a 2-cycle read latency: ain is registered, then rd_en loads the buffer's output register.

Parameters:
SIZE, 10, ring buffer address width. Must equal the buffer depth (2^SIZE words).
WIDTH, 14, sample width.
PRE, 64, samples kept before the trigger sample.
POST, 192, samples written from the trigger cycle onward. PRE+POST <= 2^SIZE; POST >= 1.

Ports:
sysclk  in  1  system clock
rst  in  1  reset
arm  in  1  pulse: start acquisition. Accepted only in IDLE.
trig  in  1  trigger, level or pulse, sampled each cycle
wr_addr  in  SIZE  buffer aout: the next address to be written
rb_dout  in  WIDTH  buffer dout
wr_en  out  1  buffer write enable
rd_en  out  1  buffer read enable
rd_addr  out  SIZE  buffer ain
out_data  out  WIDTH  readout sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_last  out  1  with out_valid: final word of the window
busy  out  1  high in every state except IDLE
trig_lost  out  1  1-cycle pulse: trig seen in ARMED before PRE samples were written

Behaviour:
- Reset: rst is synchronous, active-high; clock sysclk. While rst is high, all outputs are 0, state goes to IDLE and all counters clear. Reset mid-event discards the event; no partial readout occurs.
- States: IDLE, ARMED, POSTTRIG, RD_ADDR, RD_EN, RD_CAP, PRESENT, DONE.
- IDLE: wr_en=0. arm=1 -> ARMED next cycle; fill counter cleared.
- ARMED: wr_en=1. fill (SIZE+1 bits) increments per write and saturates at PRE.
  - trig=1 with fill<PRE -> trig_lost pulse; stay in ARMED.
  - trig=1 with fill>=PRE (PRE=0: immediately) -> latch start = wr_addr - PRE (mod 2^SIZE); post counter = 1; go to POSTTRIG. The sample written in the trigger cycle is window index PRE.
- POSTTRIG: wr_en=1 while post < POST; post increments per cycle. Total writes from the trigger cycle = POST exactly. When post==POST, wr_en=0 that cycle -> RD_ADDR. For POST=1, ARMED goes directly to RD_ADDR. trig is ignored here.
- Readout: word counter idx counts 0..PRE+POST-1; rd_addr = start + idx (mod 2^SIZE; wraps naturally).
  - RD_ADDR: present rd_addr.
  - RD_EN: rd_en=1 for exactly 1 cycle.
  - RD_CAP: capture rb_dout into out_data.
  - PRESENT: out_valid=1; out_data is stable until accepted.
  - Throughput: at most 1 word per 4 cycles.
- Handshake: a transfer occurs when out_valid & out_ready. out_valid, out_data and out_last are held until the transfer. After the transfer: if idx==PRE+POST-1 -> DONE, else idx+1 -> RD_ADDR. out_valid never drops without a transfer.
- out_last = out_valid & (idx==PRE+POST-1).
- DONE: 1 cycle, all outputs 0 except busy=1 -> IDLE. The next event requires a new arm.
- arm is ignored outside IDLE. wr_en and rd_en are never high in the same cycle.
- Arithmetic: address math is modulo 2^SIZE; counters are SIZE+1 bits so PRE+POST=2^SIZE is legal.

Decomposition:
- Shared package: state enum (3-bit encoding), and a function computing the window length PRE+POST at SIZE+1 bits.
- Sub-module: rb_read_seq, the 4-phase single-word read (RD_ADDR/RD_EN/RD_CAP/PRESENT with the valid/ready hold). It is reused by other buffer readers. The top module keeps the acquisition FSM and the counters.

Test Plan:
(Bench uses a behavioural ring buffer model with 2-cycle read latency, data = address; PRE=4, POST=8, SIZE=4.)
1. arm, 10 writes, trig when wr_addr=10 -> start=6; exactly 8 writes from trig cycle; wr_addr ends at 2; readout of 12 words 6..15,0,1 in order; out_last only on the word 1; busy falls after DONE.
2. arm, trig on 2nd ARMED cycle (fill=1) -> trig_lost pulse; no capture; later trig with fill>=4 proceeds normally.
3. Wrap: trig at wr_addr=2 after fill saturates -> start=14; read order 14,15,0..9; no address glitch at the wrap.
4. out_ready low for 7 cycles on word 3 -> out_valid and out_data held constant; no rd_en asserted during the stall; sequence resumes intact.
5. rst asserted during POSTTRIG and again during PRESENT -> next cycle all outputs 0 and state IDLE; arm restarts a clean event.
6. arm pulsed during readout and during ARMED -> no effect; check wr_en & rd_en never both high (assertion).
